// File: rtl/dmem_responder_pkg.sv
// Shared widths and FSM state encoding for the data-memory responder.
package dmem_responder_pkg;

  localparam int WORD_LEN    = 32;
  localparam int DMEM_ST_LEN = 2;

  typedef enum logic [DMEM_ST_LEN-1:0] {
    DMEM_IDLE   = 2'd0,
    DMEM_WAIT   = 2'd1,
    DMEM_ACCESS = 2'd2,
    DMEM_RESP   = 2'd3
  } dmem_st_e;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD_LEN word storage: synchronous write, asynchronous read,
// asynchronous active-low clear of every word.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [WORD_LEN-1:0] wdata_i,
  input  logic [AW-1:0]       raddr_i,
  output logic [WORD_LEN-1:0] rdata_o
);

  logic [WORD_LEN-1:0] mem_q [DEPTH];

  // Word storage: whole array cleared on reset, one word written per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// then a registered response held until the requester takes it.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int                  DEPTH       = 64,
  parameter int                  WAIT_CYCLES = 2,
  parameter logic [WORD_LEN-1:0] BASE_ADDR   = 32'd1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [WORD_LEN-1:0] req_addr,
  input  logic [WORD_LEN-1:0] req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORD_LEN-1:0] rsp_rdata,
  output logic                rsp_err
);

  localparam int                  AW       = $clog2(DEPTH);
  localparam logic [WORD_LEN-1:0] SPAN     = WORD_LEN'(4 * DEPTH);
  // Only used when WAIT_CYCLES > 0; the zero case bypasses WAIT entirely.
  localparam logic [3:0]          CNT_INIT = 4'(WAIT_CYCLES - 1);

  dmem_st_e            state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rdy_en_q;
  logic                we_q;
  logic [WORD_LEN-1:0] addr_q, wdata_q;
  logic [WORD_LEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                accept;
  logic [WORD_LEN-1:0] off;
  logic                acc_err;
  logic                mem_we;
  logic [WORD_LEN-1:0] mem_rdata;

  // rdy_en_q keeps req_ready low during reset and until the first edge after.
  assign req_ready = rdy_en_q && (state_q == DMEM_IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == DMEM_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Offset wraps, so addresses below BASE_ADDR land far out of range.
  assign off     = addr_q - BASE_ADDR;
  assign acc_err = (off[1:0] != 2'b00) || (off >= SPAN);
  assign mem_we  = (state_q == DMEM_ACCESS) && we_q && !acc_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk),
    .rst_ni  (rst),
    .we_i    (mem_we),
    .waddr_i (off[AW+1:2]),
    .wdata_i (wdata_q),
    .raddr_i (off[AW+1:2]),
    .rdata_o (mem_rdata)
  );

  // State, counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= DMEM_IDLE;
      cnt_q       <= '0;
      rdy_en_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdy_en_q    <= 1'b1;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Request capture on handshake; held until the next accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Next-state, wait countdown and response formation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      DMEM_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = DMEM_ACCESS;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == 4'd0) state_d = DMEM_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DMEM_ACCESS: begin
        state_d     = DMEM_RESP;
        rsp_err_d   = acc_err;
        rsp_rdata_d = (acc_err || we_q) ? '0 : mem_rdata;
      end
      DMEM_RESP: begin
        if (rsp_ready) state_d = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

endmodule
